arith_unit: RTL and testbench
=============================

# arith_unit

Parametrised, handshaked arithmetic unit executing one of add, subtract, multiply, divide or modulo on two W-bit unsigned operands per transaction. It is the sequential, width-generic successor to the team's combinational operator block. Add, sub and mul complete in one cycle; div and mod use a bit-serial restoring divider taking W cycles. It sits between an operand producer and a result consumer using valid/ready on both sides.

## Interface
- W, default 8: operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  unit can accept a transaction.
- op  in  3  0=ADD, 1=SUB, 2=MUL, 3=DIV, 4=MOD, 5..7 reserved.
- a  in  W  first operand (dividend for DIV/MOD).
- b  in  W  second operand (divisor for DIV/MOD).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  2W  result, zero-extended as defined under Operation.
- flag  out  1  ADD carry-out, SUB borrow, DIV/MOD divide-by-zero, reserved-op error; 0 for MUL.

## Operation
- Single transaction in flight. States: IDLE, BUSY, DONE.
- in_ready = 1 only in IDLE. Accept = in_valid & in_ready. a, b and op are registered on accept; later input changes have no effect.
- IDLE, accept, op in {ADD, SUB, MUL, reserved}: compute, register result and flag, go to DONE.
- IDLE, accept, op in {DIV, MOD}, b != 0: load dividend and divisor, clear remainder and counter, go to BUSY.
- IDLE, accept, op in {DIV, MOD}, b == 0: go to DONE with flag=1. DIV result = {W zeros, W ones}; MOD result = zero-extended a.
- BUSY: one restoring step per cycle: shift remainder left, bring in next dividend MSB, subtract divisor if remainder >= divisor, set quotient bit. After step W, go to DONE.
- DONE: out_valid=1; result and flag held stable until out_ready=1, then go to IDLE.
- Arithmetic, all unsigned:
  - ADD: result = zero-extended (a+b) over W+1 bits; flag = bit W.
  - SUB: result[W-1:0] = (a-b) mod 2^W, upper bits 0; flag = (a < b).
  - MUL: result = full 2W-bit product; flag = 0.
  - DIV: result = zero-extended quotient.
  - MOD: result = zero-extended remainder.
  - Reserved op: result = 0, flag = 1.
- Reset (asynchronous, any state including mid-divide): state=IDLE, in_ready=1, out_valid=0, result=0, flag=0, divider registers and counter=0. The in-flight transaction is discarded, and no partial result is presented.

## Timing
- ADD/SUB/MUL/reserved/divide-by-zero: accept in cycle N, out_valid=1 in cycle N+1.
- DIV/MOD with b != 0: accept in cycle N, out_valid=1 in cycle N+W+1.
- Result handshake completes in the cycle where out_valid & out_ready are both 1. in_ready rises the following cycle, so there is no same-cycle accept and complete.
- Minimum spacing between accepts: 2 cycles (fast ops), W+2 cycles (div/mod).
- out_valid never drops without out_ready. With out_ready held low, result and flag are stable indefinitely.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- Counter width ceil(log2(W+1)). The counter must not wrap before W steps for W=32.

## Test plan
- W=4, a=3, b=4, ADD -> result=7, flag=0, out_valid 1 cycle after accept. Then a=15, b=1 -> result=16 (bit 4 set), flag=1.
- W=4, a=3, b=4, SUB -> result[3:0]=4'b1111, upper bits 0, flag=1. Then a=3, b=4, MUL -> result=12, flag=0. Then a=15, b=15 -> result=225.
- W=4, a=3, b=2, DIV -> result=1 at cycle accept+5, in_ready=0 during BUSY. Then MOD -> result=1. Then a=15, b=4, DIV -> result=3; MOD -> result=3.
- W=4, a=9, b=0, DIV -> result=15, flag=1, latency 1. MOD -> result=9, flag=1. Then op=6 -> result=0, flag=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, a new in_valid is not accepted. Then out_ready=1 -> out_valid falls next cycle and in_ready rises.
- Assert rst_n low asynchronously mid-DIV (W=8, 4 steps in) -> out_valid=0, result=0, in_ready=1 immediately. After release, a fresh DIV 200/7 -> result=28 at cycle accept+9.

Source files
------------

// File: rtl/arith_unit_if.sv
// Producer/consumer handshake bundle for arith_unit: operand side and result side.
interface arith_if #(parameter int W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   result;
  logic             flag;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag
  );
endinterface

// File: rtl/arith_unit.sv
// Handshaked unsigned ALU: single-cycle add/sub/mul, bit-serial restoring divide/modulo.
// state | meaning
// IDLE  | waiting for an operand transaction, in_ready high
// BUSY  | restoring divider stepping, one quotient bit per cycle
// DONE  | result presented, held until the consumer takes it
module arith_unit #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  arith_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_mod_q, is_mod_d;
  logic [2*W-1:0]   result_q, result_d;
  logic             flag_q, flag_d;

  logic [W:0]       sum;
  logic [W-1:0]     diff;
  logic [2*W-1:0]   prod;
  logic [W:0]       rem_sh;
  logic [W-1:0]     rem_sub;
  logic             q_bit;
  logic [W-1:0]     rem_next;
  logic [W-1:0]     quo_next;

  // The dividend register doubles as the quotient: quotient bits shift in from the LSB.
  always_comb begin
    sum      = {1'b0, bus.a} + {1'b0, bus.b};
    diff     = bus.a - bus.b;
    prod     = (2*W)'(bus.a) * (2*W)'(bus.b);
    rem_sh   = {rem_q, dvd_q[W-1]};
    q_bit    = (rem_sh >= {1'b0, dvs_q});
    rem_sub  = rem_sh[W-1:0] - dvs_q;
    rem_next = q_bit ? rem_sub : rem_sh[W-1:0];
    quo_next = {dvd_q[W-2:0], q_bit};
  end

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    is_mod_d = is_mod_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = DONE;
          case (bus.op)
            OP_ADD: begin
              result_d = (2*W)'(sum);
              flag_d   = sum[W];
            end
            OP_SUB: begin
              result_d = (2*W)'(diff);
              flag_d   = (bus.a < bus.b);
            end
            OP_MUL: begin
              result_d = prod;
              flag_d   = 1'b0;
            end
            OP_DIV, OP_MOD: begin
              if (bus.b == '0) begin
                flag_d   = 1'b1;
                result_d = (bus.op == OP_DIV) ? (2*W)'({W{1'b1}}) : (2*W)'(bus.a);
              end else begin
                dvd_d    = bus.a;
                dvs_d    = bus.b;
                rem_d    = '0;
                cnt_d    = '0;
                is_mod_d = (bus.op == OP_MOD);
                state_d  = BUSY;
              end
            end
            default: begin
              result_d = '0;
              flag_d   = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        dvd_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          result_d = is_mod_q ? (2*W)'(rem_next) : (2*W)'(quo_next);
          flag_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      is_mod_q <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      is_mod_q <= is_mod_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flag      = flag_q;
endmodule

// File: tb/tb_arith_unit.sv
// Bench for arith_unit: W=4 and W=8 instances, vector table plus backpressure and reset sequences.
module tb_arith_unit;
  logic clk = 1'b0;
  logic rst4_n, rst8_n;

  arith_if #(.W(4)) bus4 ();
  arith_if #(.W(8)) bus8 ();

  arith_unit #(.W(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));
  arith_unit #(.W(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [15:0] res;
    logic        flag;
  } exp_t;

  typedef struct {
    bit          sel;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        flag;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic in_rdy(input bit s);
    return s ? bus8.in_ready : bus4.in_ready;
  endfunction

  function automatic logic out_vld(input bit s);
    return s ? bus8.out_valid : bus4.out_valid;
  endfunction

  function automatic logic [15:0] res_of(input bit s);
    return s ? bus8.result : {8'b0, bus4.result};
  endfunction

  function automatic logic flg_of(input bit s);
    return s ? bus8.flag : bus4.flag;
  endfunction

  task automatic drive(input bit s, input logic iv, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    if (s) begin
      bus8.in_valid = iv; bus8.op = op; bus8.a = a; bus8.b = b;
    end else begin
      bus4.in_valid = iv; bus4.op = op; bus4.a = a[3:0]; bus4.b = b[3:0];
    end
  endtask

  task automatic set_ordy(input bit s, input logic v);
    if (s) bus8.out_ready = v;
    else   bus4.out_ready = v;
  endtask

  task automatic add(input bit s, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] res, input logic flag, input int lat);
    vecs.push_back('{s, op, a, b, res, flag, lat});
  endtask

  // Called at a negedge with out_valid already high: score it, then complete the handshake.
  task automatic collect(input bit s, input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_result"}, res_of(s), e.res);
      check({name, "_flag"}, flg_of(s), e.flag);
    end
    set_ordy(s, 1'b1);
    @(negedge clk);
    set_ordy(s, 1'b0);
    check({name, "_out_valid_after"}, out_vld(s), 0);
    check({name, "_in_ready_after"}, in_rdy(s), 1);
  endtask

  task automatic run(input vec_t v, input string name);
    int n;
    drive(v.sel, 1'b1, v.op, v.a, v.b);
    sb.push_back('{v.res, v.flag});
    n = 0;
    while (!in_rdy(v.sel) && n < 50) begin @(negedge clk); n++; end
    check({name, "_accept_wait"}, n < 50, 1);
    @(posedge clk);
    @(negedge clk);
    drive(v.sel, 1'b0, 3'd7, ~v.a, ~v.b);
    check({name, "_in_ready_post_accept"}, in_rdy(v.sel), 0);
    n = 1;
    while (!out_vld(v.sel) && n < 100) begin @(negedge clk); n++; end
    check({name, "_latency"}, n, v.lat);
    collect(v.sel, name);
  endtask

  initial begin
    rst4_n = 1'b0;
    rst8_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);
    #12;
    check("rst4_in_ready", bus4.in_ready, 1);
    check("rst4_out_valid", bus4.out_valid, 0);
    check("rst4_result", bus4.result, 0);
    check("rst4_flag", bus4.flag, 0);
    check("rst8_in_ready", bus8.in_ready, 1);
    check("rst8_result", bus8.result, 0);
    @(negedge clk);
    rst4_n = 1'b1;
    rst8_n = 1'b1;
    @(negedge clk);

    add(0, 3'd0, 3, 4, 7, 0, 1);
    add(0, 3'd0, 15, 1, 16, 1, 1);
    add(0, 3'd0, 0, 0, 0, 0, 1);
    add(0, 3'd1, 3, 4, 15, 1, 1);
    add(0, 3'd1, 9, 3, 6, 0, 1);
    add(0, 3'd2, 3, 4, 12, 0, 1);
    add(0, 3'd2, 15, 15, 225, 0, 1);
    add(0, 3'd3, 3, 2, 1, 0, 5);
    add(0, 3'd4, 3, 2, 1, 0, 5);
    add(0, 3'd3, 15, 4, 3, 0, 5);
    add(0, 3'd4, 15, 4, 3, 0, 5);
    add(0, 3'd3, 15, 1, 15, 0, 5);
    add(0, 3'd4, 7, 15, 7, 0, 5);
    add(0, 3'd3, 9, 0, 15, 1, 1);
    add(0, 3'd4, 9, 0, 9, 1, 1);
    add(0, 3'd6, 5, 3, 0, 1, 1);
    add(0, 3'd7, 5, 3, 0, 1, 1);
    add(1, 3'd0, 200, 100, 300, 1, 1);
    add(1, 3'd1, 10, 20, 246, 1, 1);
    add(1, 3'd2, 255, 255, 65025, 0, 1);
    add(1, 3'd3, 255, 16, 15, 0, 9);
    add(1, 3'd4, 255, 16, 15, 0, 9);
    add(1, 3'd2, 200, 7, 1400, 0, 1);
    for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while consumer stalls, pending producer ignored.
    drive(0, 1'b1, 3'd0, 5, 6);
    sb.push_back('{16'd11, 1'b0});
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 3'd1, 8, 2);
    check("bp_out_valid", bus4.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold_result%0d", i), bus4.result, 11);
      check($sformatf("bp_hold_in_ready%0d", i), bus4.in_ready, 0);
      @(negedge clk);
    end
    sb.push_back('{16'd6, 1'b0});
    collect(0, "bp_first");
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 0, 0);
    check("bp_second_valid", bus4.out_valid, 1);
    collect(0, "bp_second");

    // Reset asserted asynchronously four divide steps into a W=8 divide.
    drive(1, 1'b1, 3'd3, 200, 7);
    check("rd_idle", bus8.in_ready, 1);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    rst8_n = 1'b0;
    #1;
    check("rd_out_valid", bus8.out_valid, 0);
    check("rd_result", bus8.result, 0);
    check("rd_in_ready", bus8.in_ready, 1);
    drive(1, 1'b0, 3'd0, 0, 0);
    @(negedge clk);
    rst8_n = 1'b1;
    @(negedge clk);
    run('{1, 3'd3, 200, 7, 28, 0, 9}, "rd_div");
    run('{1, 3'd4, 200, 7, 4, 0, 9}, "rd_mod");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
